// File: rtl/riscv_ex_result_queue_if.sv
// rtl/riscv_ex_result_queue_if.sv - EX->WB result queue handshake, forwarding and writeback bundle
interface riscv_ex_result_queue_if #(
   parameter int NUM_UNITS  = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int FIFO_DEPTH = 2
);
   localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic                            ex_valid_i;
   logic                            ex_ready_o;
   logic [SEL_W-1:0]                unit_sel_i;
   logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result_i;
   logic [ADDR_WIDTH-1:0]           waddr_i;
   logic                            we_i;
   logic                            flush_i;
   logic [ADDR_WIDTH-1:0]           fw_waddr_o;
   logic                            fw_we_o;
   logic [DATA_WIDTH-1:0]           fw_wdata_o;
   logic                            wb_valid_o;
   logic                            wb_ready_i;
   logic [ADDR_WIDTH-1:0]           wb_waddr_o;
   logic                            wb_we_o;
   logic [DATA_WIDTH-1:0]           wb_wdata_o;
   logic [CNT_W-1:0]                count_o;

   modport slave (
      input  ex_valid_i, unit_sel_i, unit_result_i, waddr_i, we_i, flush_i, wb_ready_i,
      output ex_ready_o, fw_waddr_o, fw_we_o, fw_wdata_o,
             wb_valid_o, wb_waddr_o, wb_we_o, wb_wdata_o, count_o
   );

   modport master (
      output ex_valid_i, unit_sel_i, unit_result_i, waddr_i, we_i, flush_i, wb_ready_i,
      input  ex_ready_o, fw_waddr_o, fw_we_o, fw_wdata_o,
             wb_valid_o, wb_waddr_o, wb_we_o, wb_wdata_o, count_o
   );
endinterface

// File: rtl/riscv_ex_result_queue.sv
// rtl/riscv_ex_result_queue.sv - EX result select, FIFO to WB, forwarding; RISCV_EX_RESULT_BYPASS_EN adds 0-cycle bypass
module riscv_ex_result_queue #(
   parameter int NUM_UNITS  = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int FIFO_DEPTH = 2
) (
   input logic                   clk,
   input logic                   rst,
   riscv_ex_result_queue_if.slave bus
);
   localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [ADDR_WIDTH-1:0] r_waddr_mem [FIFO_DEPTH];
   logic                  r_we_mem    [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_data_mem  [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [CNT_W-1:0]      r_count;

   logic [DATA_WIDTH-1:0] w_sel_data;
   logic                  w_empty;
   logic                  w_ready;
   logic                  w_bypass;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_wb_valid;

   function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Out-of-range selects fall through to zero.
   always_comb begin
      w_sel_data = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         if (bus.unit_sel_i == SEL_W'(k)) begin
            w_sel_data = bus.unit_result_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_empty = (r_count == '0);
   assign w_ready = (r_count < CNT_W'(FIFO_DEPTH)) | bus.wb_ready_i;

`ifdef RISCV_EX_RESULT_BYPASS_EN
   assign w_bypass = w_empty & bus.ex_valid_i & ~bus.flush_i;
`else
   assign w_bypass = 1'b0;
`endif

   // A bypassed entry consumed by WB in the same cycle never touches storage.
   assign w_push     = bus.ex_valid_i & w_ready & ~bus.flush_i & ~(w_bypass & bus.wb_ready_i);
   assign w_pop      = ~w_empty & bus.wb_ready_i;
   assign w_wb_valid = ~w_empty | w_bypass;

   assign bus.ex_ready_o = w_ready;
   assign bus.fw_waddr_o = bus.waddr_i;
   assign bus.fw_we_o    = bus.ex_valid_i & bus.we_i;
   assign bus.fw_wdata_o = w_sel_data;
   assign bus.count_o    = r_count;
   assign bus.wb_valid_o = w_wb_valid;
   assign bus.wb_waddr_o = w_bypass ? bus.waddr_i : r_waddr_mem[r_rd_ptr];
   assign bus.wb_wdata_o = w_bypass ? w_sel_data  : r_data_mem[r_rd_ptr];
   assign bus.wb_we_o    = w_wb_valid & (w_bypass ? bus.we_i : r_we_mem[r_rd_ptr]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_waddr_mem[i] <= '0;
            r_we_mem[i]    <= 1'b0;
            r_data_mem[i]  <= '0;
         end
      end else if (bus.flush_i) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (w_push) begin
            r_waddr_mem[r_wr_ptr] <= bus.waddr_i;
            r_we_mem[r_wr_ptr]    <= bus.we_i;
            r_data_mem[r_wr_ptr]  <= w_sel_data;
            r_wr_ptr              <= f_next(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_next(r_rd_ptr);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_riscv_ex_result_queue.sv
// tb/tb_riscv_ex_result_queue.sv - randomized self-checking bench with queue-based reference model
module tb_riscv_ex_result_queue;
   localparam int NU = 3;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int D  = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   riscv_ex_result_queue_if #(.NUM_UNITS(NU), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(D)) bus ();

   riscv_ex_result_queue #(.NUM_UNITS(NU), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [AW-1:0] a;
      logic          we;
      logic [DW-1:0] d;
   } ent_t;

   ent_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive at negedge, compare against the model, then advance the model at posedge.
   task automatic step(input logic r, input logic v, input logic [1:0] sel, input logic [AW-1:0] a,
                       input logic w, input logic f, input logic wr, input logic [NU*DW-1:0] res);
      logic [DW-1:0] exp_sel;
      logic          exp_ready, exp_valid, byp;
      ent_t          head;
      @(negedge clk);
      rst               = r;
      bus.ex_valid_i    = v;
      bus.unit_sel_i    = sel;
      bus.unit_result_i = res;
      bus.waddr_i       = a;
      bus.we_i          = w;
      bus.flush_i       = f;
      bus.wb_ready_i    = wr;
      #1;
      exp_sel   = (int'(sel) < NU) ? res[int'(sel)*DW +: DW] : '0;
      exp_ready = (q.size() < D) || wr;
      byp       = 1'b0;
`ifdef RISCV_EX_RESULT_BYPASS_EN
      byp = (q.size() == 0) && v && !f;
`endif
      head = '{'0, 1'b0, '0};
      if (byp) head = '{a, w, exp_sel};
      else if (q.size() > 0) head = q[0];
      exp_valid = (q.size() > 0) || byp;

      chk("ex_ready", 64'(bus.ex_ready_o), 64'(exp_ready));
      chk("fw_waddr", 64'(bus.fw_waddr_o), 64'(a));
      chk("fw_we", 64'(bus.fw_we_o), 64'(v & w));
      chk("fw_wdata", 64'(bus.fw_wdata_o), 64'(exp_sel));
      chk("wb_valid", 64'(bus.wb_valid_o), 64'(exp_valid));
      chk("wb_we", 64'(bus.wb_we_o), 64'(exp_valid & head.we));
      chk("count", 64'(bus.count_o), 64'(q.size()));
      if (exp_valid) begin
         chk("wb_waddr", 64'(bus.wb_waddr_o), 64'(head.a));
         chk("wb_wdata", 64'(bus.wb_wdata_o), 64'(head.d));
      end

      @(posedge clk);
      if (r || f) begin
         q.delete();
      end else begin
         if (exp_valid && wr && !byp) void'(q.pop_front());
         if (v && exp_ready && !(byp && wr)) q.push_back('{a, w, exp_sel});
      end
   endtask

   task automatic idle(input logic wr);
      step(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, wr, '0);
   endtask

   logic [NU*DW-1:0] r_abc;

   initial begin
      r_abc = {32'h33, 32'h22, 32'h11};

      // Reset for two cycles.
      step(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, '0);
      #1;
      chk("rst_count", 64'(bus.count_o), 64'd0);
      chk("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
      chk("rst_wb_we", 64'(bus.wb_we_o), 64'd0);
      chk("rst_ex_ready", 64'(bus.ex_ready_o), 64'd1);
      chk("rst_wb_waddr", 64'(bus.wb_waddr_o), 64'd0);
      chk("rst_wb_wdata", 64'(bus.wb_wdata_o), 64'd0);

      // Unit select and 1-cycle latency.
      step(1'b0, 1'b1, 2'd1, 5'd7, 1'b1, 1'b0, 1'b1, r_abc);
      #1;
      chk("t2_fw_wdata", 64'(bus.fw_wdata_o), 64'h22);
`ifndef RISCV_EX_RESULT_BYPASS_EN
      chk("t2_wb_valid", 64'(bus.wb_valid_o), 64'd1);
      chk("t2_wb_wdata", 64'(bus.wb_wdata_o), 64'h22);
      chk("t2_wb_waddr", 64'(bus.wb_waddr_o), 64'd7);
`endif
      idle(1'b1);

      // Fill with WB stalled, third entry held by the source, then drain.
      step(1'b0, 1'b1, 2'd0, 5'd1, 1'b1, 1'b0, 1'b0, {64'h0, 32'h101});
      step(1'b0, 1'b1, 2'd0, 5'd2, 1'b0, 1'b0, 1'b0, {64'h0, 32'h102});
      #1;
      chk("t3_count_full", 64'(bus.count_o), 64'd2);
      chk("t3_ready_full", 64'(bus.ex_ready_o), 64'd0);
      step(1'b0, 1'b1, 2'd0, 5'd3, 1'b1, 1'b0, 1'b0, {64'h0, 32'h103});
      step(1'b0, 1'b1, 2'd0, 5'd3, 1'b1, 1'b0, 1'b1, {64'h0, 32'h103});
      for (int i = 0; i < 3; i++) idle(1'b1);
      #1;
      chk("t3_count_drained", 64'(bus.count_o), 64'd0);

      // Simultaneous pop/push on a full queue with pointer wrap.
      step(1'b0, 1'b1, 2'd2, 5'd4, 1'b1, 1'b0, 1'b0, {32'h201, 64'h0});
      step(1'b0, 1'b1, 2'd2, 5'd5, 1'b1, 1'b0, 1'b0, {32'h202, 64'h0});
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 2'd2, 5'(8 + i), 1'b1, 1'b0, 1'b1, {32'(32'hAA + i), 64'h0});
         #1;
         chk("t4_count_steady", 64'(bus.count_o), 64'd2);
      end
      for (int i = 0; i < 2; i++) idle(1'b1);

      // Flush wins over a concurrent push; out-of-range select.
      step(1'b0, 1'b1, 2'd0, 5'd9, 1'b1, 1'b0, 1'b0, {64'h0, 32'h301});
      step(1'b0, 1'b1, 2'd0, 5'd10, 1'b1, 1'b0, 1'b0, {64'h0, 32'h302});
      step(1'b0, 1'b1, 2'd0, 5'd11, 1'b1, 1'b1, 1'b0, {64'h0, 32'h303});
      #1;
      chk("t5_count_flush", 64'(bus.count_o), 64'd0);
      chk("t5_valid_flush", 64'(bus.wb_valid_o), 64'd0);
      step(1'b0, 1'b1, 2'd3, 5'd12, 1'b1, 1'b0, 1'b0, r_abc);
      #1;
      chk("t5_sel_oor", 64'(bus.fw_wdata_o), 64'd0);
      for (int i = 0; i < 2; i++) idle(1'b1);

      // Randomized traffic including occasional flush and reset.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) == 0,
              1'($urandom_range(0, 2) != 0),
              2'($urandom_range(0, 3)),
              AW'($urandom),
              1'($urandom),
              $urandom_range(0, 15) == 0,
              1'($urandom_range(0, 2) != 0),
              {$urandom, $urandom, $urandom});
      end
      for (int i = 0; i < 4; i++) idle(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
